// File: rtl/clash_pkg.sv
// ============================================================================
// clash_pkg: unit attack target codes and game state shared by spawner,
// range logic and the tower damage resolver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clash_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [CODE_W-1:0] {
    CODE_NONE  = 3'd0,
    TGT_RTOWER = 3'd1,
    TGT_LTOWER = 3'd2,
    TGT_KING   = 3'd3
  } target_e;

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    OVER = 1'b1
  } game_state_e;

endpackage

`default_nettype wire

// File: rtl/tower_hp.sv
// ============================================================================
// tower_hp: one tower's HP, sticky destroyed flag and hit-flash frame counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tower_hp #(
  parameter int RELOAD_HP    = 100,
  parameter int HIT_DMG      = 5,
  parameter int FLASH_FRAMES = 8,
  parameter int HP_W         = 8,
  parameter int MAX_HITS     = 4,
  localparam int HITS_W      = $clog2(MAX_HITS + 1),
  localparam int FL_W        = $clog2(FLASH_FRAMES + 1)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic [HITS_W-1:0] i_hits,
  input  logic              i_freeze,
  output logic [HP_W-1:0]   o_hp,
  output logic              o_destroyed,
  output logic              o_flash,
  output logic              o_dies
);

  localparam int DW = HP_W + 3;

  logic [HP_W-1:0] r_hp;
  logic            r_destroyed;
  logic [FL_W-1:0] r_flash_cnt;

  logic [DW-1:0]   w_dmg;
  logic [DW-1:0]   w_hp_ext;
  logic [HP_W-1:0] w_hp_next;
  logic            w_accept;

  assign w_dmg     = DW'(i_hits) * DW'(HIT_DMG);
  assign w_hp_ext  = DW'(r_hp);
  assign w_hp_next = (w_hp_ext > w_dmg) ? HP_W'(w_hp_ext - w_dmg) : '0;
  assign w_accept  = i_tick & ~i_freeze & ~r_destroyed & (i_hits != '0);
  // Lets the top switch to OVER on the same edge the king hits zero.
  assign o_dies    = w_accept & (w_hp_next == '0);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hp        <= HP_W'(RELOAD_HP);
      r_destroyed <= 1'b0;
      r_flash_cnt <= '0;
    end else if (i_freeze) begin
      r_flash_cnt <= '0;
    end else if (i_tick) begin
      if (w_accept) begin
        r_hp        <= w_hp_next;
        r_flash_cnt <= FL_W'(FLASH_FRAMES);
        if (w_hp_next == '0) r_destroyed <= 1'b1;
      end else if (r_flash_cnt != '0) begin
        r_flash_cnt <= r_flash_cnt - FL_W'(1);
      end
    end
  end

  assign o_hp        = r_hp;
  assign o_destroyed = r_destroyed;
  assign o_flash     = (r_flash_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/tower_damage_resolver.sv
// ============================================================================
// tower_damage_resolver: samples unit attack codes once per frame and applies
// damage to right, left and king towers; tracks game-over.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tower_damage_resolver
  import clash_pkg::*;
#(
  parameter int NUM_UNITS    = 4,
  parameter int TOWER_HP     = 100,
  parameter int KING_HP      = 150,
  parameter int HIT_DMG      = 5,
  parameter int HP_W         = 8,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic [3*NUM_UNITS-1:0] attackindex,
  output logic                   towerrd,
  output logic                   towerld,
  output logic                   kingd,
  output logic [HP_W-1:0]        hp_r,
  output logic [HP_W-1:0]        hp_l,
  output logic [HP_W-1:0]        hp_k,
  output logic                   flash_r,
  output logic                   flash_l,
  output logic                   flash_k,
  output logic                   game_over
);

  localparam int HITS_W = $clog2(NUM_UNITS + 1);

  logic r_vs_meta, r_vs_sync, r_vs_prev, r_tick;
  game_state_e r_state;
  logic r_game_over;

  logic [HITS_W-1:0] w_hits_r, w_hits_l, w_hits_k;
  logic w_dies_r, w_dies_l, w_dies_k;
  logic w_freeze;

  // The extra r_tick stage gives the spawners' vsync-edge update time to settle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_tick    <= r_vs_sync & ~r_vs_prev;
    end
  end

  always_comb begin
    w_hits_r = '0;
    w_hits_l = '0;
    w_hits_k = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (attackindex[3*i +: 3] == TGT_RTOWER) w_hits_r = w_hits_r + HITS_W'(1);
      if (attackindex[3*i +: 3] == TGT_LTOWER) w_hits_l = w_hits_l + HITS_W'(1);
      if (attackindex[3*i +: 3] == TGT_KING)   w_hits_k = w_hits_k + HITS_W'(1);
    end
  end

  assign w_freeze = (r_state == OVER);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state     <= PLAY;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_dies_k) begin
            r_state     <= OVER;
            r_game_over <= 1'b1;
          end
        end
        OVER: begin
          r_state     <= OVER;
          r_game_over <= 1'b1;
        end
        default: begin
          r_state     <= PLAY;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  tower_hp #(
    .RELOAD_HP(TOWER_HP), .HIT_DMG(HIT_DMG), .FLASH_FRAMES(FLASH_FRAMES),
    .HP_W(HP_W), .MAX_HITS(NUM_UNITS)
  ) u_tower_r (
    .vga_clk(vga_clk), .reset(reset), .i_tick(r_tick), .i_hits(w_hits_r),
    .i_freeze(w_freeze), .o_hp(hp_r), .o_destroyed(towerrd), .o_flash(flash_r),
    .o_dies(w_dies_r)
  );

  tower_hp #(
    .RELOAD_HP(TOWER_HP), .HIT_DMG(HIT_DMG), .FLASH_FRAMES(FLASH_FRAMES),
    .HP_W(HP_W), .MAX_HITS(NUM_UNITS)
  ) u_tower_l (
    .vga_clk(vga_clk), .reset(reset), .i_tick(r_tick), .i_hits(w_hits_l),
    .i_freeze(w_freeze), .o_hp(hp_l), .o_destroyed(towerld), .o_flash(flash_l),
    .o_dies(w_dies_l)
  );

  tower_hp #(
    .RELOAD_HP(KING_HP), .HIT_DMG(HIT_DMG), .FLASH_FRAMES(FLASH_FRAMES),
    .HP_W(HP_W), .MAX_HITS(NUM_UNITS)
  ) u_tower_k (
    .vga_clk(vga_clk), .reset(reset), .i_tick(r_tick), .i_hits(w_hits_k),
    .i_freeze(w_freeze), .o_hp(hp_k), .o_destroyed(kingd), .o_flash(flash_k),
    .o_dies(w_dies_k)
  );

  assign game_over = r_game_over;

  // Side-tower death has no game-level effect; only the flags are exported.
  logic w_unused;
  assign w_unused = w_dies_r | w_dies_l;

endmodule

`default_nettype wire

// File: tb/tb_tower_damage_resolver.sv
// ============================================================================
// tb_tower_damage_resolver: directed frames with a scoreboard of expected
// tower state per frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tower_damage_resolver;

  localparam int TOWER_HP = 100;
  // 153 lets the king be worn down to exactly 3 HP with 5-point hits.
  localparam int KING_HP  = 153;
  localparam int DMG      = 5;
  localparam int FLASHN   = 8;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        vsync   = 1'b0;
  logic [11:0] attackindex = '0;
  logic        towerrd, towerld, kingd, flash_r, flash_l, flash_k, game_over;
  logic [7:0]  hp_r, hp_l, hp_k;

  tower_damage_resolver #(
    .NUM_UNITS(4), .TOWER_HP(TOWER_HP), .KING_HP(KING_HP), .HIT_DMG(DMG),
    .HP_W(8), .FLASH_FRAMES(FLASHN)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .vsync(vsync), .attackindex(attackindex),
    .towerrd(towerrd), .towerld(towerld), .kingd(kingd),
    .hp_r(hp_r), .hp_l(hp_l), .hp_k(hp_k),
    .flash_r(flash_r), .flash_l(flash_l), .flash_k(flash_k),
    .game_over(game_over)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int hp[3];
    bit dest[3];
    bit fl[3];
    bit go;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_hp[3];
  bit m_dest[3];
  int m_fc[3];
  bit m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hp[0] = TOWER_HP; m_hp[1] = TOWER_HP; m_hp[2] = KING_HP;
    for (int t = 0; t < 3; t++) begin
      m_dest[t] = 1'b0;
      m_fc[t]   = 0;
    end
    m_over = 1'b0;
  endtask

  // Advances the model by one frame tick and queues the expected outputs.
  task automatic model_frame(input logic [11:0] ai);
    int   hits[3];
    exp_t e;
    logic [11:0] v;
    v = ai;
    for (int t = 0; t < 3; t++) hits[t] = 0;
    for (int u = 0; u < 4; u++) begin
      if (v[3*u +: 3] == 3'd1) hits[0]++;
      if (v[3*u +: 3] == 3'd2) hits[1]++;
      if (v[3*u +: 3] == 3'd3) hits[2]++;
    end
    if (!m_over) begin
      for (int t = 0; t < 3; t++) begin
        if (!m_dest[t] && hits[t] > 0) begin
          m_hp[t] = (m_hp[t] > hits[t] * DMG) ? m_hp[t] - hits[t] * DMG : 0;
          if (m_hp[t] == 0) m_dest[t] = 1'b1;
          m_fc[t] = FLASHN;
        end else if (m_fc[t] > 0) begin
          m_fc[t]--;
        end
      end
      if (m_dest[2]) m_over = 1'b1;
    end
    if (m_over) for (int t = 0; t < 3; t++) m_fc[t] = 0;
    for (int t = 0; t < 3; t++) begin
      e.hp[t]   = m_hp[t];
      e.dest[t] = m_dest[t];
      e.fl[t]   = (m_fc[t] != 0);
    end
    e.go = m_over;
    sb.push_back(e);
  endtask

  task automatic compare_state(input exp_t e);
    check("hp_r", hp_r, e.hp[0]);
    check("hp_l", hp_l, e.hp[1]);
    check("hp_k", hp_k, e.hp[2]);
    check("towerrd", towerrd, e.dest[0]);
    check("towerld", towerld, e.dest[1]);
    check("kingd", kingd, e.dest[2]);
    check("flash_r", flash_r, e.fl[0]);
    check("flash_l", flash_l, e.fl[1]);
    check("flash_k", flash_k, e.fl[2]);
    check("game_over", game_over, e.go);
  endtask

  // One vsync period; codes are held through the low phase too, where they must not count.
  task automatic frame(input logic [11:0] ai);
    exp_t e;
    @(negedge vga_clk);
    vsync = 1'b1;
    attackindex = ai;
    model_frame(ai);
    repeat (6) @(negedge vga_clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      compare_state(e);
    end
    vsync = 1'b0;
    repeat (4) @(negedge vga_clk);
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset = 1'b1;
    vsync = 1'b0;
    attackindex = '0;
    repeat (2) @(negedge vga_clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic check_reload(input string tag);
    check({tag, "_hp_r"}, hp_r, TOWER_HP);
    check({tag, "_hp_l"}, hp_l, TOWER_HP);
    check({tag, "_hp_k"}, hp_k, KING_HP);
    check({tag, "_flags"}, {towerrd, towerld, kingd}, 3'b000);
    check({tag, "_flash"}, {flash_r, flash_l, flash_k}, 3'b000);
    check({tag, "_game_over"}, game_over, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();
    check_reload("reset");

    repeat (10) frame(12'h000);

    frame({3'd0, 3'd0, 3'd0, 3'd1});
    check("single_hit_hp_r", hp_r, TOWER_HP - DMG);
    repeat (7) frame(12'h000);
    check("flash_r_last_frame", flash_r, 1'b1);
    frame(12'h000);
    check("flash_r_expired", flash_r, 1'b0);

    frame({4{3'd2}});
    check("quad_hit_hp_l", hp_l, TOWER_HP - 4 * DMG);
    repeat (4) frame({4{3'd2}});
    check("hp_l_zero", hp_l, 0);
    check("towerld_set", towerld, 1'b1);
    repeat (2) frame({4{3'd2}});
    check("towerld_sticky", towerld, 1'b1);

    for (int f = 0; f < 20; f++) begin
      case (f % 4)
        0: frame({3'd7, 3'd6, 3'd5, 3'd4});
        1: frame({3'd4, 3'd7, 3'd6, 3'd5});
        2: frame({3'd5, 3'd4, 3'd7, 3'd6});
        default: frame({4{3'd4 + 3'(f % 4)}});
      endcase
    end
    check("ignored_codes_hp_r", hp_r, TOWER_HP - DMG);

    repeat (2) frame({4{3'd1}});
    frame({3'd0, 3'd1, 3'd1, 3'd1});
    check("pre_reset_hp_r", hp_r, 40);
    check("pre_reset_flash_r", flash_r, 1'b1);

    // Reset lands on the edge where the tick would apply these hits.
    @(negedge vga_clk);
    vsync = 1'b1;
    attackindex = {4{3'd1}};
    repeat (3) @(negedge vga_clk);
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
    vsync = 1'b0;
    attackindex = '0;
    model_reset();
    repeat (6) @(negedge vga_clk);
    check_reload("tick_reset");
    frame(12'h000);

    repeat (7) frame({4{3'd3}});
    frame({3'd0, 3'd0, 3'd3, 3'd3});
    check("king_hp_3", hp_k, 3);
    frame({3'd0, 3'd0, 3'd3, 3'd3});
    check("king_hp_zero", hp_k, 0);
    check("kingd_set", kingd, 1'b1);
    check("game_over_set", game_over, 1'b1);
    repeat (3) frame({3'd1, 3'd1, 3'd2, 3'd3});
    check("over_hp_r_frozen", hp_r, TOWER_HP);
    check("over_flash_k_clear", flash_k, 1'b0);

    do_reset();
    check_reload("over_reset");
    frame({3'd0, 3'd0, 3'd0, 3'd3});
    check("after_over_king_hit", hp_k, KING_HP - DMG);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
